// File: rtl/wb_ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_ctrl_pipe_pkg
// Brief    : Shared widths, write-back select encodings and stage-record layout
//            for the write-back control pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package wb_ctrl_pipe_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int WBSEL_W   = 4;

    localparam logic [WBSEL_W-1:0] WBSEL_MAC = 4'b0001;
    localparam logic [WBSEL_W-1:0] WBSEL_ALU = 4'b0010;
    localparam logic [WBSEL_W-1:0] WBSEL_DM  = 4'b0100;

    // Record layout, LSB first: cond_en, wbsel, waddr, we, valid [, cond]
    localparam int STG_CEN_BIT   = 0;
    localparam int STG_WBSEL_LSB = 1;

    function automatic int stg_waddr_lsb(input int sw);
        return STG_WBSEL_LSB + sw;
    endfunction

    function automatic int stg_we_bit(input int aw, input int sw);
        return stg_waddr_lsb(sw) + aw;
    endfunction

    function automatic int stg_valid_bit(input int aw, input int sw);
        return stg_we_bit(aw, sw) + 1;
    endfunction

    // Width of a record without the cond bit; cond sits just above it.
    function automatic int stg_base_w(input int aw, input int sw);
        return stg_valid_bit(aw, sw) + 1;
    endfunction

endpackage : wb_ctrl_pipe_pkg
`default_nettype wire

// File: rtl/wb_ctrl_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_reg
// Brief    : One pipeline stage register with clear > load > hold priority.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_reg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : wb_stage_reg
`default_nettype wire

// File: rtl/wb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_ctrl_pipe
// Brief    : Write-back control pipeline P3..WB with stall bubbles, flush kills
//            and conditional-execution qualification of the RF write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module wb_ctrl_pipe #(
    parameter int RF_ADDR_W = wb_ctrl_pipe_pkg::RF_ADDR_W,
    parameter int WBSEL_W   = wb_ctrl_pipe_pkg::WBSEL_W
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic                 id_rf_we_i,
    input  logic [RF_ADDR_W-1:0] id_rf_waddr_i,
    input  logic [WBSEL_W-1:0]   id_wbsel_i,
    input  logic                 id_cond_en_i,
    input  logic                 flag_cond_i,
    output logic                 p4_we_o,
    output logic [RF_ADDR_W-1:0] p4_waddr_o,
    output logic [WBSEL_W-1:0]   p4_wbsel_o,
    output logic                 p5_we_o,
    output logic [RF_ADDR_W-1:0] p5_waddr_o,
    output logic [WBSEL_W-1:0]   p5_wbsel_o,
    output logic                 cond_p4_o,
    output logic                 cond_p5_o,
    output logic                 cond_wb_o,
    output logic                 wb_we_o,
    output logic [RF_ADDR_W-1:0] wb_waddr_o,
    output logic [WBSEL_W-1:0]   wb_wbsel_o
);

    import wb_ctrl_pipe_pkg::*;

    localparam int c_base_w    = stg_base_w(RF_ADDR_W, WBSEL_W);
    localparam int c_full_w    = c_base_w + 1;
    localparam int c_waddr_lsb = stg_waddr_lsb(WBSEL_W);
    localparam int c_we_bit    = stg_we_bit(RF_ADDR_W, WBSEL_W);
    localparam int c_valid_bit = stg_valid_bit(RF_ADDR_W, WBSEL_W);
    localparam int c_cond_bit  = c_base_w;

    logic [c_base_w-1:0] w_id_stage;
    logic [c_base_w-1:0] r_p3;
    logic [c_base_w-1:0] r_p4;
    logic [c_full_w-1:0] w_p5_d;
    logic [c_full_w-1:0] r_p5;
    logic [c_full_w-1:0] r_wb;
    logic                w_cond_p4;

    // An invalid decode slot becomes an all-zero bubble before entering P3.
    assign w_id_stage = id_valid_i ?
                        {1'b1, id_rf_we_i, id_rf_waddr_i, id_wbsel_i, id_cond_en_i} :
                        '0;

    // Flush outranks stall: the clear path wins even while load is held off.
    wb_stage_reg #(.WIDTH(c_base_w)) u_p3 (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_load  (~stall_i),
        .i_clear (flush_i),
        .i_d     (w_id_stage),
        .o_q     (r_p3)
    );

    wb_stage_reg #(.WIDTH(c_base_w)) u_p4 (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_load  (1'b1),
        .i_clear (stall_i),
        .i_d     (r_p3),
        .o_q     (r_p4)
    );

    assign w_cond_p4 = ~r_p4[STG_CEN_BIT] | flag_cond_i;
    assign w_p5_d    = {w_cond_p4, r_p4};

    wb_stage_reg #(.WIDTH(c_full_w)) u_p5 (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_load  (1'b1),
        .i_clear (1'b0),
        .i_d     (w_p5_d),
        .o_q     (r_p5)
    );

    wb_stage_reg #(.WIDTH(c_full_w)) u_wb (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_load  (1'b1),
        .i_clear (1'b0),
        .i_d     (r_p5),
        .o_q     (r_wb)
    );

    assign p4_we_o    = r_p4[c_valid_bit] & r_p4[c_we_bit];
    assign p4_waddr_o = r_p4[c_waddr_lsb +: RF_ADDR_W];
    assign p4_wbsel_o = r_p4[STG_WBSEL_LSB +: WBSEL_W];
    assign cond_p4_o  = w_cond_p4;

    assign p5_we_o    = r_p5[c_valid_bit] & r_p5[c_we_bit];
    assign p5_waddr_o = r_p5[c_waddr_lsb +: RF_ADDR_W];
    assign p5_wbsel_o = r_p5[STG_WBSEL_LSB +: WBSEL_W];
    assign cond_p5_o  = r_p5[c_cond_bit];

    // A failed condition only masks the strobe; the slot still drains normally.
    assign wb_we_o    = r_wb[c_valid_bit] & r_wb[c_we_bit] & r_wb[c_cond_bit];
    assign wb_waddr_o = r_wb[c_waddr_lsb +: RF_ADDR_W];
    assign wb_wbsel_o = r_wb[STG_WBSEL_LSB +: WBSEL_W];
    assign cond_wb_o  = r_wb[c_cond_bit];

endmodule : wb_ctrl_pipe
`default_nettype wire

// File: tb/tb_wb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ctrl_pipe
// Brief    : Directed scoreboard bench for wb_ctrl_pipe; a negedge monitor pops
//            expected RF writes whenever wb_we_o is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ctrl_pipe;

    import wb_ctrl_pipe_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic                 stall_i;
    logic                 flush_i;
    logic                 id_valid_i;
    logic                 id_rf_we_i;
    logic [RF_ADDR_W-1:0] id_rf_waddr_i;
    logic [WBSEL_W-1:0]   id_wbsel_i;
    logic                 id_cond_en_i;
    logic                 flag_cond_i;
    logic                 p4_we_o;
    logic [RF_ADDR_W-1:0] p4_waddr_o;
    logic [WBSEL_W-1:0]   p4_wbsel_o;
    logic                 p5_we_o;
    logic [RF_ADDR_W-1:0] p5_waddr_o;
    logic [WBSEL_W-1:0]   p5_wbsel_o;
    logic                 cond_p4_o;
    logic                 cond_p5_o;
    logic                 cond_wb_o;
    logic                 wb_we_o;
    logic [RF_ADDR_W-1:0] wb_waddr_o;
    logic [WBSEL_W-1:0]   wb_wbsel_o;

    wb_ctrl_pipe #(
        .RF_ADDR_W (RF_ADDR_W),
        .WBSEL_W   (WBSEL_W)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .id_valid_i    (id_valid_i),
        .id_rf_we_i    (id_rf_we_i),
        .id_rf_waddr_i (id_rf_waddr_i),
        .id_wbsel_i    (id_wbsel_i),
        .id_cond_en_i  (id_cond_en_i),
        .flag_cond_i   (flag_cond_i),
        .p4_we_o       (p4_we_o),
        .p4_waddr_o    (p4_waddr_o),
        .p4_wbsel_o    (p4_wbsel_o),
        .p5_we_o       (p5_we_o),
        .p5_waddr_o    (p5_waddr_o),
        .p5_wbsel_o    (p5_wbsel_o),
        .cond_p4_o     (cond_p4_o),
        .cond_p5_o     (cond_p5_o),
        .cond_wb_o     (cond_wb_o),
        .wb_we_o       (wb_we_o),
        .wb_waddr_o    (wb_waddr_o),
        .wb_wbsel_o    (wb_wbsel_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int                   cyc;
        logic [RF_ADDR_W-1:0] waddr;
        logic [WBSEL_W-1:0]   wbsel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input logic [RF_ADDR_W-1:0] a, input logic [WBSEL_W-1:0] s);
        exp_t e;
        e.cyc   = c;
        e.waddr = a;
        e.wbsel = s;
        sb.push_back(e);
    endtask

    // Any non-zero strobe must match the oldest expected write, on its cycle.
    always @(negedge clk) begin
        if (wb_we_o !== 1'b0) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_wb_we: got pulse waddr=%0d at cycle %0d, expected none",
                         wb_waddr_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("wb_cycle", cyc, mon_e.cyc);
                check("wb_waddr", wb_waddr_o, mon_e.waddr);
                check("wb_wbsel", wb_wbsel_o, mon_e.wbsel);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [RF_ADDR_W-1:0] a,
                         input logic [WBSEL_W-1:0] s, input logic cen);
        id_valid_i    = v;
        id_rf_we_i    = we;
        id_rf_waddr_i = a;
        id_wbsel_i    = s;
        id_cond_en_i  = cen;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    int c0;

    initial begin
        reset_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        flag_cond_i = 1'b1;
        idle();
        tick(); tick();

        check("rst_p4_we", p4_we_o, 0);
        check("rst_p5_we", p5_we_o, 0);
        check("rst_wb_we", wb_we_o, 0);
        check("rst_p4_waddr", p4_waddr_o, 0);
        check("rst_cond_p5", cond_p5_o, 0);
        check("rst_cond_wb", cond_wb_o, 0);
        check("rst_cond_p4_bubble", cond_p4_o, 1);
        reset_i = 1'b0;
        tick();

        // Straight flow
        c0 = cyc;
        drive(1'b1, 1'b1, 5'd7, WBSEL_ALU, 1'b0);
        push(c0 + 4, 5'd7, WBSEL_ALU);
        tick(); idle();
        check("flow_p4_we_e1", p4_we_o, 0);
        tick();
        check("flow_p4_we_e2", p4_we_o, 1);
        check("flow_p4_waddr", p4_waddr_o, 7);
        check("flow_p4_wbsel", p4_wbsel_o, WBSEL_ALU);
        tick();
        check("flow_p4_we_e3", p4_we_o, 0);
        check("flow_p5_we_e3", p5_we_o, 1);
        check("flow_p5_waddr", p5_waddr_o, 7);
        tick();
        check("flow_p5_we_e4", p5_we_o, 0);
        tick(); tick();

        // Stall two cycles with A in P3
        c0 = cyc;
        drive(1'b1, 1'b1, 5'd3, WBSEL_ALU, 1'b0);
        push(c0 + 6, 5'd3, WBSEL_ALU);
        tick(); idle();
        stall_i = 1'b1;
        tick();
        check("stall_bubble1_p4_we", p4_we_o, 0);
        tick();
        check("stall_bubble2_p4_we", p4_we_o, 0);
        stall_i = 1'b0;
        tick();
        check("stall_release_p4_we", p4_we_o, 1);
        check("stall_release_p4_waddr", p4_waddr_o, 3);
        tick(); tick(); tick(); tick();

        // Flush together with stall kills A in P3
        drive(1'b1, 1'b1, 5'd11, WBSEL_DM, 1'b0);
        tick(); idle();
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        check("flush_p4_we_bubble", p4_we_o, 0);
        stall_i = 1'b0;
        flush_i = 1'b0;
        tick();
        check("flush_next_p4_we", p4_we_o, 0);
        check("flush_next_p4_waddr", p4_waddr_o, 0);
        tick();
        check("flush_p5_we", p5_we_o, 0);
        tick(); tick(); tick();

        // Conditional fail
        drive(1'b1, 1'b1, 5'd9, WBSEL_ALU, 1'b1);
        tick(); idle();
        tick();
        flag_cond_i = 1'b0;
        #1;
        check("cfail_cond_p4", cond_p4_o, 0);
        check("cfail_p4_we", p4_we_o, 1);
        check("cfail_p4_waddr", p4_waddr_o, 9);
        tick();
        flag_cond_i = 1'b1;
        check("cfail_cond_p5", cond_p5_o, 0);
        check("cfail_p5_we", p5_we_o, 1);
        tick();
        check("cfail_cond_wb", cond_wb_o, 0);
        tick(); tick();

        // Conditional pass, MAC then ALU back-to-back to the same register
        c0 = cyc;
        drive(1'b1, 1'b1, 5'd4, WBSEL_MAC, 1'b1);
        push(c0 + 4, 5'd4, WBSEL_MAC);
        tick();
        drive(1'b1, 1'b1, 5'd4, WBSEL_ALU, 1'b1);
        push(c0 + 5, 5'd4, WBSEL_ALU);
        tick(); idle();
        check("cpass_cond_p4", cond_p4_o, 1);
        tick();
        check("b2b_p5_wbsel", p5_wbsel_o, WBSEL_MAC);
        check("b2b_p4_wbsel", p4_wbsel_o, WBSEL_ALU);
        check("b2b_cond_p5", cond_p5_o, 1);
        tick();
        check("b2b_cond_wb", cond_wb_o, 1);
        tick(); tick(); tick();

        // Asynchronous reset with three instructions in flight
        drive(1'b1, 1'b1, 5'd1, WBSEL_ALU, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd2, WBSEL_ALU, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd3, WBSEL_ALU, 1'b0);
        tick(); idle();
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_p4_we", p4_we_o, 0);
        check("arst_p4_waddr", p4_waddr_o, 0);
        check("arst_p5_we", p5_we_o, 0);
        check("arst_p5_waddr", p5_waddr_o, 0);
        check("arst_wb_we", wb_we_o, 0);
        check("arst_cond_p5", cond_p5_o, 0);
        tick(); tick();
        reset_i = 1'b0;
        repeat (6) tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_wb_ctrl_pipe
`default_nettype wire

// File: doc/wb_ctrl_pipe.md
Name: wb_ctrl_pipe

Overview:
- Carries per-instruction register-file write-back control from decode through pipeline stages P3, P4, P5 and WB.
- Produces the destination/enable/mux-select and condition signals that forwarding control consumes for P4, P5 and WB.
- Produces the final register-file write strobe.
- Sits between the decoder and the forwarding control / register-file write port.
- Owns stall bubbles, flush kills and conditional-execution qualification.

Parameters:
RF_ADDR_W, 5, register-file address width (32 GPRs)
WBSEL_W, 4, write-back mux select width (0001 = MAC result in P5, 0010 = ALU result in P4, 0100 = DM load)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
stall_i  in  1  hold ID/P3, inject bubble into P4
flush_i  in  1  kill instruction in ID and P3 (taken jump)
id_valid_i  in  1  decoder presents an instruction
id_rf_we_i  in  1  instruction writes RF
id_rf_waddr_i  in  RF_ADDR_W  destination register
id_wbsel_i  in  WBSEL_W  result source select
id_cond_en_i  in  1  instruction is conditional
flag_cond_i  in  1  condition evaluated by flag unit in P4 (combinational)
p4_we_o  out  1  P4 write-enable (for forwarding)
p4_waddr_o  out  RF_ADDR_W  P4 destination
p4_wbsel_o  out  WBSEL_W  P4 mux select
p5_we_o  out  1  P5 write-enable
p5_waddr_o  out  RF_ADDR_W  P5 destination
p5_wbsel_o  out  WBSEL_W  P5 mux select
cond_p4_o  out  1  P4 instruction condition passes
cond_p5_o  out  1  registered condition, P5
cond_wb_o  out  1  registered condition, WB
wb_we_o  out  1  final RF write strobe (we & cond & valid)
wb_waddr_o  out  RF_ADDR_W  RF write address
wb_wbsel_o  out  WBSEL_W  WB mux select

Behaviour:
Interface
- One clock, clk_i.
- Reset reset_i is asynchronous and active-high.
- On reset, every stage register clears: valid=0, we=0, waddr=0, wbsel=0, cond_en=0, cond=0.
- All registered outputs read 0 during and after reset until the first instruction arrives.
- Reset mid-operation discards all in-flight instructions; no wb_we_o pulse follows.

Stage registers
- Each of P3, P4, P5 and WB holds {valid, we, waddr, wbsel, cond_en}.
- P5 and WB additionally hold cond.

Advance rules (per rising edge)
- No stall, no flush: ID→P3, P3→P4, P4→P5, P5→WB.
- stall_i=1: P3 holds its value; P4 loads a bubble (all zero); P5 and WB advance normally.
- flush_i=1: P3 loads a bubble; ID contents are dropped; P4, P5 and WB advance normally.
- stall_i and flush_i together: flush wins. P3 is cleared and P4 still receives a bubble.
- id_valid_i=0: P3 loads a bubble.

Outputs
- pN_we_o = valid & we of stage N. Address and select outputs are driven from the stage register regardless of valid.
- cond_p4_o = ~P4.cond_en | flag_cond_i. This is combinational, so it is same-cycle with P4.
- The P5 cond register captures cond_p4_o on advance. WB captures P5.cond.
- cond_p5_o and cond_wb_o come straight from registers.
- wb_we_o = WB.valid & WB.we & WB.cond.
- A failed condition suppresses the write but does not stall the pipeline.
- Bubbles have cond_en=0 and valid=0, so they never assert any we output.

Latency
- A decoded instruction appears in P4 two edges after acceptance and in WB four edges after, with no stalls.
- Each stall cycle adds one cycle for instructions at P3 or earlier.

Decomposition:
- Shared package/defines: RF_ADDR_W, WBSEL_W, the WBSEL_* encodings, and a stage-control record width/field macros matching the existing FWD_* slicing style.
- One sub-module is natural: wb_stage_reg.
  - One stage register with load/hold/clear controls.
  - Instantiated four times.
  - P5 and WB instances carry the cond bit.

Test Plan:
- Reset: assert reset_i mid-stream with three instructions in flight → all outputs 0 immediately (async); no wb_we_o pulse afterwards.
- Straight flow: id_valid=1, we=1, waddr=7, wbsel=0010, unconditional → p4_we_o=1 and waddr=7 at edge 2, p5_we_o at edge 3, wb_we_o=1 and waddr=7 at edge 4, each for exactly one cycle.
- Stall: instruction A (waddr=3) in P3, stall_i=1 for 2 cycles → P4 shows two bubbles (p4_we_o=0), A reaches P4 on the first non-stalled edge, and its WB is delayed by exactly 2 cycles.
- Flush with stall: A in P3, stall_i=1 and flush_i=1 in the same cycle → A never reaches P4, and the next P4 is a bubble.
- Conditional fail: cond_en=1, waddr=9, flag_cond_i=0 while in P4 → cond_p4_o=0, cond_p5_o=0 next cycle, wb_we_o stays 0 at WB.
- Conditional pass with back-to-back: MAC (wbsel=0001, waddr=4), then ALU (wbsel=0010, waddr=4), flag=1 → p5_wbsel_o=0001 and p4_wbsel_o=0010 in the same cycle; two consecutive wb_we_o pulses with waddr=4.
